dpsk_diff_tx: RTL

Differential (DPSK) baseband transmitter for the 200 kbit/s link. It takes bytes over a valid/ready handshake, sends a lock preamble, then shifts the bytes out MSB first as a differentially encoded NRZ level. It runs at 32× oversampling on clk32_i and also drives a bit-rate reference clock. It is the far-end source whose data edges the receive DPLL phase detector tracks against its I/Q bit clocks.

---
 rtl/dpsk_pkg.sv | 14 +
 rtl/dpsk_bit_timer.sv | 53 +++++
 rtl/dpsk_diff_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dpsk_pkg.sv
// dpsk_pkg: shared DPSK link types and constants.
// Used by the transmitter and the receive DPLL.
package dpsk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } dpsk_state_e;

  localparam int DPSK_OSR          = 32;
  localparam int DPSK_PREAMBLE_LEN = 16;

endpackage

// File: rtl/dpsk_bit_timer.sv
// dpsk_bit_timer: oversampling counter and bit clock.
// Ports:
//   clk32_i, rst_n_i : clock, async active-low reset
//   i_run            : transmitter is in a frame now
//   i_en             : transmitter is in a frame next cycle
//   o_bit_end        : current cycle is the last of a bit
//   o_bit_start      : next edge enters count 0
//   o_bit_clk        : registered, high for first OSR/2
module dpsk_bit_timer #(
  parameter int OSR = 32
) (
  input  logic clk32_i,
  input  logic rst_n_i,
  input  logic i_run,
  input  logic i_en,
  output logic o_bit_end,
  output logic o_bit_start,
  output logic o_bit_clk
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [CW-1:0] HALF = CW'(OSR / 2);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_bit_clk;

  assign o_bit_end = i_run && (r_cnt == LAST);

  // Count is held at 0 outside a frame, so
  // the edge leaving IDLE is itself a bit start.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_run && !o_bit_end) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign o_bit_start = i_en && (w_cnt_nxt == '0);
  assign o_bit_clk   = r_bit_clk;

  always_ff @(posedge clk32_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt     <= '0;
      r_bit_clk <= 1'b0;
    end else begin
      r_cnt     <= i_en ? w_cnt_nxt : '0;
      r_bit_clk <= i_en && (w_cnt_nxt < HALF);
    end
  end

endmodule

// File: rtl/dpsk_diff_tx.sv
// dpsk_diff_tx: DPSK baseband transmitter, 32x clock.
// Ports:
//   clk32_i, rst_n_i : clock, async active-low reset
//   tx_data_i/valid  : byte in, MSB first
//   tx_ready_o       : holding register empty
//   data_o           : differentially encoded level
//   bit_clk_o        : bit-rate reference clock
//   busy_o           : frame in progress
module dpsk_diff_tx
  import dpsk_pkg::*;
#(
  parameter int OSR             = DPSK_OSR,
  parameter int PREAMBLE_LEN    = DPSK_PREAMBLE_LEN,
  parameter bit DIFF_ONE_TOGGLE = 1'b1
) (
  input  logic       clk32_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       data_o,
  output logic       bit_clk_o,
  output logic       busy_o
);

  localparam logic [7:0] PRE_LAST =
    8'(PREAMBLE_LEN - 1);

  dpsk_state_e r_state;
  dpsk_state_e w_state_nxt;

  logic [7:0] r_bit_cnt;
  logic [7:0] r_hold_q;
  logic [7:0] r_shift;
  logic       r_hold_full;
  logic       r_data;
  logic       r_busy;

  logic [7:0] w_src;
  logic       w_run;
  logic       w_en;
  logic       w_bit_end;
  logic       w_bit_start;
  logic       w_bit_clk;
  logic       w_accept;
  logic       w_pre_last;
  logic       w_byte_last;
  logic       w_load;
  logic       w_bit;
  logic       w_enc;

  assign w_accept    = tx_valid_i && !r_hold_full;
  assign w_pre_last  = (r_state == PREAMBLE) &&
                       (r_bit_cnt == PRE_LAST);
  assign w_byte_last = (r_state == DATA) &&
                       (r_bit_cnt == 8'd7);

  // A byte accepted on the reload edge bypasses
  // the holding register.
  assign w_src = r_hold_full ? r_hold_q : tx_data_i;

  assign w_load = w_bit_end &&
                  (w_pre_last ||
                   (w_byte_last &&
                    (r_hold_full || w_accept)));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_hold_full) w_state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        if (w_bit_end && w_pre_last)
          w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end && w_byte_last &&
            !(r_hold_full || w_accept))
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_run = (r_state != IDLE);
  assign w_en  = (w_state_nxt != IDLE);

  dpsk_bit_timer #(
    .OSR(OSR)
  ) u_timer (
    .clk32_i     (clk32_i),
    .rst_n_i     (rst_n_i),
    .i_run       (w_run),
    .i_en        (w_en),
    .o_bit_end   (w_bit_end),
    .o_bit_start (w_bit_start),
    .o_bit_clk   (w_bit_clk)
  );

  // Bit that begins on the next edge. Within a
  // byte the next bit sits at r_shift[6].
  always_comb begin
    w_bit = 1'b1;
    if (w_state_nxt == DATA) begin
      w_bit = w_load ? w_src[7] : r_shift[6];
    end
  end

  assign w_enc = DIFF_ONE_TOGGLE ? w_bit : ~w_bit;

  always_ff @(posedge clk32_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_hold_q    <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_data      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_en;

      if (w_bit_start) r_data <= r_data ^ w_enc;

      if (!w_en) begin
        r_bit_cnt <= '0;
      end else if (w_bit_end) begin
        if (w_pre_last || w_byte_last)
          r_bit_cnt <= '0;
        else
          r_bit_cnt <= r_bit_cnt + 8'd1;
      end

      if (w_load) begin
        r_shift <= w_src;
      end else if (w_bit_end && r_state == DATA) begin
        r_shift <= {r_shift[6:0], 1'b0};
      end

      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept && !w_load) begin
        r_hold_q    <= tx_data_i;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign tx_ready_o = !r_hold_full;
  assign data_o     = r_data;
  assign bit_clk_o  = w_bit_clk;
  assign busy_o     = r_busy;

endmodule
